// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 arbiter with independent read and write grant FSMs.
// Optional AXI_ARB_RR_EN: round-robin tie-break instead of fixed LSU priority.

module axi_arb_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,    // {LSU, IFU}
  input  logic       done,   // last response handshake of the granted transaction
  output logic [1:0] grant   // one-hot {LSU, IFU}
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_IFU, ARB_LSU} arb_state_e;
  arb_state_e state, state_nxt;
  logic       lsu_wins;

`ifdef AXI_ARB_RR_EN
  logic last_lsu;
  // Remembers who was granted last so a tie goes to the other master.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                        last_lsu <= 1'b0;
    else if (state == ARB_IDLE && state_nxt != ARB_IDLE) last_lsu <= (state_nxt == ARB_LSU);
  assign lsu_wins = !last_lsu;
`else
  assign lsu_wins = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (req[1] && (!req[0] || lsu_wins)) state_nxt = ARB_LSU;
        else if (req[0])                     state_nxt = ARB_IFU;
      end
      ARB_IFU, ARB_LSU: if (done) state_nxt = ARB_IDLE;
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign grant = {state == ARB_LSU, state == ARB_IFU};
endmodule

module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU master
  input  logic [ID_W-1:0]     IFU_AXI_ARID,
  input  logic [ADDR_W-1:0]   IFU_AXI_ARADDR,
  input  logic [7:0]          IFU_AXI_ARLEN,
  input  logic [2:0]          IFU_AXI_ARSIZE,
  input  logic [1:0]          IFU_AXI_ARBURST,
  input  logic                IFU_AXI_ARVALID,
  output logic                IFU_AXI_ARREADY,
  output logic [ID_W-1:0]     IFU_AXI_RID,
  output logic [DATA_W-1:0]   IFU_AXI_RDATA,
  output logic [1:0]          IFU_AXI_RRESP,
  output logic                IFU_AXI_RLAST,
  output logic                IFU_AXI_RVALID,
  input  logic                IFU_AXI_RREADY,
  input  logic [ID_W-1:0]     IFU_AXI_AWID,
  input  logic [ADDR_W-1:0]   IFU_AXI_AWADDR,
  input  logic [7:0]          IFU_AXI_AWLEN,
  input  logic [2:0]          IFU_AXI_AWSIZE,
  input  logic [1:0]          IFU_AXI_AWBURST,
  input  logic                IFU_AXI_AWVALID,
  output logic                IFU_AXI_AWREADY,
  input  logic [DATA_W-1:0]   IFU_AXI_WDATA,
  input  logic [DATA_W/8-1:0] IFU_AXI_WSTRB,
  input  logic                IFU_AXI_WLAST,
  input  logic                IFU_AXI_WVALID,
  output logic                IFU_AXI_WREADY,
  output logic [ID_W-1:0]     IFU_AXI_BID,
  output logic [1:0]          IFU_AXI_BRESP,
  output logic                IFU_AXI_BVALID,
  input  logic                IFU_AXI_BREADY,
  // LSU master
  input  logic [ID_W-1:0]     LSU_AXI_ARID,
  input  logic [ADDR_W-1:0]   LSU_AXI_ARADDR,
  input  logic [7:0]          LSU_AXI_ARLEN,
  input  logic [2:0]          LSU_AXI_ARSIZE,
  input  logic [1:0]          LSU_AXI_ARBURST,
  input  logic                LSU_AXI_ARVALID,
  output logic                LSU_AXI_ARREADY,
  output logic [ID_W-1:0]     LSU_AXI_RID,
  output logic [DATA_W-1:0]   LSU_AXI_RDATA,
  output logic [1:0]          LSU_AXI_RRESP,
  output logic                LSU_AXI_RLAST,
  output logic                LSU_AXI_RVALID,
  input  logic                LSU_AXI_RREADY,
  input  logic [ID_W-1:0]     LSU_AXI_AWID,
  input  logic [ADDR_W-1:0]   LSU_AXI_AWADDR,
  input  logic [7:0]          LSU_AXI_AWLEN,
  input  logic [2:0]          LSU_AXI_AWSIZE,
  input  logic [1:0]          LSU_AXI_AWBURST,
  input  logic                LSU_AXI_AWVALID,
  output logic                LSU_AXI_AWREADY,
  input  logic [DATA_W-1:0]   LSU_AXI_WDATA,
  input  logic [DATA_W/8-1:0] LSU_AXI_WSTRB,
  input  logic                LSU_AXI_WLAST,
  input  logic                LSU_AXI_WVALID,
  output logic                LSU_AXI_WREADY,
  output logic [ID_W-1:0]     LSU_AXI_BID,
  output logic [1:0]          LSU_AXI_BRESP,
  output logic                LSU_AXI_BVALID,
  input  logic                LSU_AXI_BREADY,
  // memory slave
  output logic [ID_W-1:0]     MEM_AXI_ARID,
  output logic [ADDR_W-1:0]   MEM_AXI_ARADDR,
  output logic [7:0]          MEM_AXI_ARLEN,
  output logic [2:0]          MEM_AXI_ARSIZE,
  output logic [1:0]          MEM_AXI_ARBURST,
  output logic                MEM_AXI_ARVALID,
  input  logic                MEM_AXI_ARREADY,
  input  logic [ID_W-1:0]     MEM_AXI_RID,
  input  logic [DATA_W-1:0]   MEM_AXI_RDATA,
  input  logic [1:0]          MEM_AXI_RRESP,
  input  logic                MEM_AXI_RLAST,
  input  logic                MEM_AXI_RVALID,
  output logic                MEM_AXI_RREADY,
  output logic [ID_W-1:0]     MEM_AXI_AWID,
  output logic [ADDR_W-1:0]   MEM_AXI_AWADDR,
  output logic [7:0]          MEM_AXI_AWLEN,
  output logic [2:0]          MEM_AXI_AWSIZE,
  output logic [1:0]          MEM_AXI_AWBURST,
  output logic                MEM_AXI_AWVALID,
  input  logic                MEM_AXI_AWREADY,
  output logic [DATA_W-1:0]   MEM_AXI_WDATA,
  output logic [DATA_W/8-1:0] MEM_AXI_WSTRB,
  output logic                MEM_AXI_WLAST,
  output logic                MEM_AXI_WVALID,
  input  logic                MEM_AXI_WREADY,
  input  logic [ID_W-1:0]     MEM_AXI_BID,
  input  logic [1:0]          MEM_AXI_BRESP,
  input  logic                MEM_AXI_BVALID,
  output logic                MEM_AXI_BREADY,
  output logic [1:0]          rd_grant,
  output logic [1:0]          wr_grant
);
  logic rd_done, wr_done;

  assign rd_done = MEM_AXI_RVALID & MEM_AXI_RREADY & MEM_AXI_RLAST;
  assign wr_done = MEM_AXI_BVALID & MEM_AXI_BREADY;

  axi_arb_fsm u_rd_fsm (
    .clk(clk), .rst_n(rst_n), .req({LSU_AXI_ARVALID, IFU_AXI_ARVALID}),
    .done(rd_done), .grant(rd_grant));

  axi_arb_fsm u_wr_fsm (
    .clk(clk), .rst_n(rst_n), .req({LSU_AXI_AWVALID, IFU_AXI_AWVALID}),
    .done(wr_done), .grant(wr_grant));

  // Response payloads broadcast; only the granted master sees VALID.
  assign IFU_AXI_RID   = MEM_AXI_RID;   assign LSU_AXI_RID   = MEM_AXI_RID;
  assign IFU_AXI_RDATA = MEM_AXI_RDATA; assign LSU_AXI_RDATA = MEM_AXI_RDATA;
  assign IFU_AXI_RRESP = MEM_AXI_RRESP; assign LSU_AXI_RRESP = MEM_AXI_RRESP;
  assign IFU_AXI_RLAST = MEM_AXI_RLAST; assign LSU_AXI_RLAST = MEM_AXI_RLAST;
  assign IFU_AXI_BID   = MEM_AXI_BID;   assign LSU_AXI_BID   = MEM_AXI_BID;
  assign IFU_AXI_BRESP = MEM_AXI_BRESP; assign LSU_AXI_BRESP = MEM_AXI_BRESP;

  always_comb begin
    MEM_AXI_ARID    = '0;
    MEM_AXI_ARADDR  = '0;
    MEM_AXI_ARLEN   = '0;
    MEM_AXI_ARSIZE  = '0;
    MEM_AXI_ARBURST = '0;
    MEM_AXI_ARVALID = 1'b0;
    MEM_AXI_RREADY  = 1'b0;
    IFU_AXI_ARREADY = 1'b0;
    LSU_AXI_ARREADY = 1'b0;
    IFU_AXI_RVALID  = 1'b0;
    LSU_AXI_RVALID  = 1'b0;
    if (rd_grant[0]) begin
      MEM_AXI_ARID    = IFU_AXI_ARID;
      MEM_AXI_ARADDR  = IFU_AXI_ARADDR;
      MEM_AXI_ARLEN   = IFU_AXI_ARLEN;
      MEM_AXI_ARSIZE  = IFU_AXI_ARSIZE;
      MEM_AXI_ARBURST = IFU_AXI_ARBURST;
      MEM_AXI_ARVALID = IFU_AXI_ARVALID;
      MEM_AXI_RREADY  = IFU_AXI_RREADY;
      IFU_AXI_ARREADY = MEM_AXI_ARREADY;
      IFU_AXI_RVALID  = MEM_AXI_RVALID;
    end else if (rd_grant[1]) begin
      MEM_AXI_ARID    = LSU_AXI_ARID;
      MEM_AXI_ARADDR  = LSU_AXI_ARADDR;
      MEM_AXI_ARLEN   = LSU_AXI_ARLEN;
      MEM_AXI_ARSIZE  = LSU_AXI_ARSIZE;
      MEM_AXI_ARBURST = LSU_AXI_ARBURST;
      MEM_AXI_ARVALID = LSU_AXI_ARVALID;
      MEM_AXI_RREADY  = LSU_AXI_RREADY;
      LSU_AXI_ARREADY = MEM_AXI_ARREADY;
      LSU_AXI_RVALID  = MEM_AXI_RVALID;
    end
  end

  // W may run ahead of AW: both channels pass through for the whole grant.
  always_comb begin
    MEM_AXI_AWID    = '0;
    MEM_AXI_AWADDR  = '0;
    MEM_AXI_AWLEN   = '0;
    MEM_AXI_AWSIZE  = '0;
    MEM_AXI_AWBURST = '0;
    MEM_AXI_AWVALID = 1'b0;
    MEM_AXI_WDATA   = '0;
    MEM_AXI_WSTRB   = '0;
    MEM_AXI_WLAST   = 1'b0;
    MEM_AXI_WVALID  = 1'b0;
    MEM_AXI_BREADY  = 1'b0;
    IFU_AXI_AWREADY = 1'b0;
    LSU_AXI_AWREADY = 1'b0;
    IFU_AXI_WREADY  = 1'b0;
    LSU_AXI_WREADY  = 1'b0;
    IFU_AXI_BVALID  = 1'b0;
    LSU_AXI_BVALID  = 1'b0;
    if (wr_grant[0]) begin
      MEM_AXI_AWID    = IFU_AXI_AWID;
      MEM_AXI_AWADDR  = IFU_AXI_AWADDR;
      MEM_AXI_AWLEN   = IFU_AXI_AWLEN;
      MEM_AXI_AWSIZE  = IFU_AXI_AWSIZE;
      MEM_AXI_AWBURST = IFU_AXI_AWBURST;
      MEM_AXI_AWVALID = IFU_AXI_AWVALID;
      MEM_AXI_WDATA   = IFU_AXI_WDATA;
      MEM_AXI_WSTRB   = IFU_AXI_WSTRB;
      MEM_AXI_WLAST   = IFU_AXI_WLAST;
      MEM_AXI_WVALID  = IFU_AXI_WVALID;
      MEM_AXI_BREADY  = IFU_AXI_BREADY;
      IFU_AXI_AWREADY = MEM_AXI_AWREADY;
      IFU_AXI_WREADY  = MEM_AXI_WREADY;
      IFU_AXI_BVALID  = MEM_AXI_BVALID;
    end else if (wr_grant[1]) begin
      MEM_AXI_AWID    = LSU_AXI_AWID;
      MEM_AXI_AWADDR  = LSU_AXI_AWADDR;
      MEM_AXI_AWLEN   = LSU_AXI_AWLEN;
      MEM_AXI_AWSIZE  = LSU_AXI_AWSIZE;
      MEM_AXI_AWBURST = LSU_AXI_AWBURST;
      MEM_AXI_AWVALID = LSU_AXI_AWVALID;
      MEM_AXI_WDATA   = LSU_AXI_WDATA;
      MEM_AXI_WSTRB   = LSU_AXI_WSTRB;
      MEM_AXI_WLAST   = LSU_AXI_WLAST;
      MEM_AXI_WVALID  = LSU_AXI_WVALID;
      MEM_AXI_BREADY  = LSU_AXI_BREADY;
      LSU_AXI_AWREADY = MEM_AXI_AWREADY;
      LSU_AXI_WREADY  = MEM_AXI_WREADY;
      LSU_AXI_BVALID  = MEM_AXI_BVALID;
    end
  end
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: read-path vector table, directed corner sequences,
// then random traffic against an ownership-based reference model.
module tb_axi_mem_arbiter;
  logic clk, rst_n;
  logic [3:0]  IFU_AXI_ARID, LSU_AXI_ARID, MEM_AXI_ARID, IFU_AXI_RID, LSU_AXI_RID, MEM_AXI_RID;
  logic [3:0]  IFU_AXI_AWID, LSU_AXI_AWID, MEM_AXI_AWID, IFU_AXI_BID, LSU_AXI_BID, MEM_AXI_BID;
  logic [31:0] IFU_AXI_ARADDR, LSU_AXI_ARADDR, MEM_AXI_ARADDR, IFU_AXI_AWADDR, LSU_AXI_AWADDR, MEM_AXI_AWADDR;
  logic [7:0]  IFU_AXI_ARLEN, LSU_AXI_ARLEN, MEM_AXI_ARLEN, IFU_AXI_AWLEN, LSU_AXI_AWLEN, MEM_AXI_AWLEN;
  logic [7:0]  IFU_AXI_WSTRB, LSU_AXI_WSTRB, MEM_AXI_WSTRB;
  logic [2:0]  IFU_AXI_ARSIZE, LSU_AXI_ARSIZE, MEM_AXI_ARSIZE, IFU_AXI_AWSIZE, LSU_AXI_AWSIZE, MEM_AXI_AWSIZE;
  logic [1:0]  IFU_AXI_ARBURST, LSU_AXI_ARBURST, MEM_AXI_ARBURST, IFU_AXI_AWBURST, LSU_AXI_AWBURST, MEM_AXI_AWBURST;
  logic [1:0]  IFU_AXI_RRESP, LSU_AXI_RRESP, MEM_AXI_RRESP, IFU_AXI_BRESP, LSU_AXI_BRESP, MEM_AXI_BRESP;
  logic [63:0] IFU_AXI_RDATA, LSU_AXI_RDATA, MEM_AXI_RDATA, IFU_AXI_WDATA, LSU_AXI_WDATA, MEM_AXI_WDATA;
  logic IFU_AXI_ARVALID, LSU_AXI_ARVALID, MEM_AXI_ARVALID, IFU_AXI_ARREADY, LSU_AXI_ARREADY, MEM_AXI_ARREADY;
  logic IFU_AXI_RLAST, LSU_AXI_RLAST, MEM_AXI_RLAST, IFU_AXI_RVALID, LSU_AXI_RVALID, MEM_AXI_RVALID;
  logic IFU_AXI_RREADY, LSU_AXI_RREADY, MEM_AXI_RREADY;
  logic IFU_AXI_AWVALID, LSU_AXI_AWVALID, MEM_AXI_AWVALID, IFU_AXI_AWREADY, LSU_AXI_AWREADY, MEM_AXI_AWREADY;
  logic IFU_AXI_WLAST, LSU_AXI_WLAST, MEM_AXI_WLAST, IFU_AXI_WVALID, LSU_AXI_WVALID, MEM_AXI_WVALID;
  logic IFU_AXI_WREADY, LSU_AXI_WREADY, MEM_AXI_WREADY;
  logic IFU_AXI_BVALID, LSU_AXI_BVALID, MEM_AXI_BVALID, IFU_AXI_BREADY, LSU_AXI_BREADY, MEM_AXI_BREADY;
  logic [1:0] rd_grant, wr_grant;

  axi_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFU_AXI_ARID(IFU_AXI_ARID), .IFU_AXI_ARADDR(IFU_AXI_ARADDR), .IFU_AXI_ARLEN(IFU_AXI_ARLEN),
    .IFU_AXI_ARSIZE(IFU_AXI_ARSIZE), .IFU_AXI_ARBURST(IFU_AXI_ARBURST), .IFU_AXI_ARVALID(IFU_AXI_ARVALID),
    .IFU_AXI_ARREADY(IFU_AXI_ARREADY), .IFU_AXI_RID(IFU_AXI_RID), .IFU_AXI_RDATA(IFU_AXI_RDATA),
    .IFU_AXI_RRESP(IFU_AXI_RRESP), .IFU_AXI_RLAST(IFU_AXI_RLAST), .IFU_AXI_RVALID(IFU_AXI_RVALID),
    .IFU_AXI_RREADY(IFU_AXI_RREADY), .IFU_AXI_AWID(IFU_AXI_AWID), .IFU_AXI_AWADDR(IFU_AXI_AWADDR),
    .IFU_AXI_AWLEN(IFU_AXI_AWLEN), .IFU_AXI_AWSIZE(IFU_AXI_AWSIZE), .IFU_AXI_AWBURST(IFU_AXI_AWBURST),
    .IFU_AXI_AWVALID(IFU_AXI_AWVALID), .IFU_AXI_AWREADY(IFU_AXI_AWREADY), .IFU_AXI_WDATA(IFU_AXI_WDATA),
    .IFU_AXI_WSTRB(IFU_AXI_WSTRB), .IFU_AXI_WLAST(IFU_AXI_WLAST), .IFU_AXI_WVALID(IFU_AXI_WVALID),
    .IFU_AXI_WREADY(IFU_AXI_WREADY), .IFU_AXI_BID(IFU_AXI_BID), .IFU_AXI_BRESP(IFU_AXI_BRESP),
    .IFU_AXI_BVALID(IFU_AXI_BVALID), .IFU_AXI_BREADY(IFU_AXI_BREADY),
    .LSU_AXI_ARID(LSU_AXI_ARID), .LSU_AXI_ARADDR(LSU_AXI_ARADDR), .LSU_AXI_ARLEN(LSU_AXI_ARLEN),
    .LSU_AXI_ARSIZE(LSU_AXI_ARSIZE), .LSU_AXI_ARBURST(LSU_AXI_ARBURST), .LSU_AXI_ARVALID(LSU_AXI_ARVALID),
    .LSU_AXI_ARREADY(LSU_AXI_ARREADY), .LSU_AXI_RID(LSU_AXI_RID), .LSU_AXI_RDATA(LSU_AXI_RDATA),
    .LSU_AXI_RRESP(LSU_AXI_RRESP), .LSU_AXI_RLAST(LSU_AXI_RLAST), .LSU_AXI_RVALID(LSU_AXI_RVALID),
    .LSU_AXI_RREADY(LSU_AXI_RREADY), .LSU_AXI_AWID(LSU_AXI_AWID), .LSU_AXI_AWADDR(LSU_AXI_AWADDR),
    .LSU_AXI_AWLEN(LSU_AXI_AWLEN), .LSU_AXI_AWSIZE(LSU_AXI_AWSIZE), .LSU_AXI_AWBURST(LSU_AXI_AWBURST),
    .LSU_AXI_AWVALID(LSU_AXI_AWVALID), .LSU_AXI_AWREADY(LSU_AXI_AWREADY), .LSU_AXI_WDATA(LSU_AXI_WDATA),
    .LSU_AXI_WSTRB(LSU_AXI_WSTRB), .LSU_AXI_WLAST(LSU_AXI_WLAST), .LSU_AXI_WVALID(LSU_AXI_WVALID),
    .LSU_AXI_WREADY(LSU_AXI_WREADY), .LSU_AXI_BID(LSU_AXI_BID), .LSU_AXI_BRESP(LSU_AXI_BRESP),
    .LSU_AXI_BVALID(LSU_AXI_BVALID), .LSU_AXI_BREADY(LSU_AXI_BREADY),
    .MEM_AXI_ARID(MEM_AXI_ARID), .MEM_AXI_ARADDR(MEM_AXI_ARADDR), .MEM_AXI_ARLEN(MEM_AXI_ARLEN),
    .MEM_AXI_ARSIZE(MEM_AXI_ARSIZE), .MEM_AXI_ARBURST(MEM_AXI_ARBURST), .MEM_AXI_ARVALID(MEM_AXI_ARVALID),
    .MEM_AXI_ARREADY(MEM_AXI_ARREADY), .MEM_AXI_RID(MEM_AXI_RID), .MEM_AXI_RDATA(MEM_AXI_RDATA),
    .MEM_AXI_RRESP(MEM_AXI_RRESP), .MEM_AXI_RLAST(MEM_AXI_RLAST), .MEM_AXI_RVALID(MEM_AXI_RVALID),
    .MEM_AXI_RREADY(MEM_AXI_RREADY), .MEM_AXI_AWID(MEM_AXI_AWID), .MEM_AXI_AWADDR(MEM_AXI_AWADDR),
    .MEM_AXI_AWLEN(MEM_AXI_AWLEN), .MEM_AXI_AWSIZE(MEM_AXI_AWSIZE), .MEM_AXI_AWBURST(MEM_AXI_AWBURST),
    .MEM_AXI_AWVALID(MEM_AXI_AWVALID), .MEM_AXI_AWREADY(MEM_AXI_AWREADY), .MEM_AXI_WDATA(MEM_AXI_WDATA),
    .MEM_AXI_WSTRB(MEM_AXI_WSTRB), .MEM_AXI_WLAST(MEM_AXI_WLAST), .MEM_AXI_WVALID(MEM_AXI_WVALID),
    .MEM_AXI_WREADY(MEM_AXI_WREADY), .MEM_AXI_BID(MEM_AXI_BID), .MEM_AXI_BRESP(MEM_AXI_BRESP),
    .MEM_AXI_BVALID(MEM_AXI_BVALID), .MEM_AXI_BREADY(MEM_AXI_BREADY),
    .rd_grant(rd_grant), .wr_grant(wr_grant));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0, total = 0;
  // Reference model: current owner of each path (0 none, 1 IFU, 2 LSU) and last winner.
  int  rown, wown;
  bit  r_last_lsu, w_last_lsu;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic clr();
    {IFU_AXI_ARID, IFU_AXI_ARADDR, IFU_AXI_ARLEN, IFU_AXI_ARSIZE, IFU_AXI_ARBURST, IFU_AXI_ARVALID, IFU_AXI_RREADY} = '0;
    {LSU_AXI_ARID, LSU_AXI_ARADDR, LSU_AXI_ARLEN, LSU_AXI_ARSIZE, LSU_AXI_ARBURST, LSU_AXI_ARVALID, LSU_AXI_RREADY} = '0;
    {IFU_AXI_AWID, IFU_AXI_AWADDR, IFU_AXI_AWLEN, IFU_AXI_AWSIZE, IFU_AXI_AWBURST, IFU_AXI_AWVALID} = '0;
    {LSU_AXI_AWID, LSU_AXI_AWADDR, LSU_AXI_AWLEN, LSU_AXI_AWSIZE, LSU_AXI_AWBURST, LSU_AXI_AWVALID} = '0;
    {IFU_AXI_WDATA, IFU_AXI_WSTRB, IFU_AXI_WLAST, IFU_AXI_WVALID, IFU_AXI_BREADY} = '0;
    {LSU_AXI_WDATA, LSU_AXI_WSTRB, LSU_AXI_WLAST, LSU_AXI_WVALID, LSU_AXI_BREADY} = '0;
    {MEM_AXI_ARREADY, MEM_AXI_RID, MEM_AXI_RDATA, MEM_AXI_RRESP, MEM_AXI_RLAST, MEM_AXI_RVALID} = '0;
    {MEM_AXI_AWREADY, MEM_AXI_WREADY, MEM_AXI_BID, MEM_AXI_BRESP, MEM_AXI_BVALID} = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr();
    @(posedge clk); #1 rst_n = 1'b1;
    rown = 0; wown = 0; r_last_lsu = 0; w_last_lsu = 0;
  endtask

  task automatic step(); @(posedge clk); #1; endtask

  task automatic rand_in();
    IFU_AXI_ARVALID = 1'($urandom_range(0, 1)); LSU_AXI_ARVALID = 1'($urandom_range(0, 1));
    IFU_AXI_AWVALID = 1'($urandom_range(0, 1)); LSU_AXI_AWVALID = 1'($urandom_range(0, 1));
    IFU_AXI_WVALID  = 1'($urandom_range(0, 1)); LSU_AXI_WVALID  = 1'($urandom_range(0, 1));
    IFU_AXI_RREADY  = 1'($urandom_range(0, 1)); LSU_AXI_RREADY  = 1'($urandom_range(0, 1));
    IFU_AXI_BREADY  = 1'($urandom_range(0, 1)); LSU_AXI_BREADY  = 1'($urandom_range(0, 1));
    IFU_AXI_ARADDR = $urandom; LSU_AXI_ARADDR = $urandom;
    IFU_AXI_AWADDR = $urandom; LSU_AXI_AWADDR = $urandom;
    IFU_AXI_WSTRB = 8'($urandom); LSU_AXI_WSTRB = 8'($urandom);
    MEM_AXI_ARREADY = 1'($urandom_range(0, 1)); MEM_AXI_AWREADY = 1'($urandom_range(0, 1));
    MEM_AXI_WREADY  = 1'($urandom_range(0, 1));
    MEM_AXI_RVALID  = 1'($urandom_range(0, 1));
    MEM_AXI_RLAST   = ($urandom_range(0, 2) == 0);
    MEM_AXI_BVALID  = ($urandom_range(0, 2) == 0);
  endtask

  // Tie-break rule: fixed build favours LSU, round-robin build favours whoever lost last time.
  function automatic int pick(logic i, logic l, bit last_lsu);
    if (i && l) begin
`ifdef AXI_ARB_RR_EN
      return last_lsu ? 1 : 2;
`else
      return 2;
`endif
    end
    if (l) return 2;
    if (i) return 1;
    return 0;
  endfunction

  task automatic model_step();
    bit rel_r, rel_w;
    rel_r = MEM_AXI_RVALID && MEM_AXI_RLAST && ((rown == 1 && IFU_AXI_RREADY) || (rown == 2 && LSU_AXI_RREADY));
    rel_w = MEM_AXI_BVALID && ((wown == 1 && IFU_AXI_BREADY) || (wown == 2 && LSU_AXI_BREADY));
    if (rown == 0) begin
      rown = pick(IFU_AXI_ARVALID, LSU_AXI_ARVALID, r_last_lsu);
      if (rown != 0) r_last_lsu = (rown == 2);
    end else if (rel_r) rown = 0;
    if (wown == 0) begin
      wown = pick(IFU_AXI_AWVALID, LSU_AXI_AWVALID, w_last_lsu);
      if (wown != 0) w_last_lsu = (wown == 2);
    end else if (rel_w) wown = 0;
  endtask

  function automatic logic [90:0] exp_vec();
    logic ri, rl, wi, wl;
    ri = (rown == 1); rl = (rown == 2); wi = (wown == 1); wl = (wown == 2);
    return {rl, ri, (ri & IFU_AXI_ARVALID) | (rl & LSU_AXI_ARVALID),
            ri ? IFU_AXI_ARADDR : rl ? LSU_AXI_ARADDR : 32'h0,
            ri & MEM_AXI_ARREADY, rl & MEM_AXI_ARREADY, ri & MEM_AXI_RVALID, rl & MEM_AXI_RVALID,
            (ri & IFU_AXI_RREADY) | (rl & LSU_AXI_RREADY),
            wl, wi, (wi & IFU_AXI_AWVALID) | (wl & LSU_AXI_AWVALID),
            wi ? IFU_AXI_AWADDR : wl ? LSU_AXI_AWADDR : 32'h0,
            (wi & IFU_AXI_WVALID) | (wl & LSU_AXI_WVALID),
            wi ? IFU_AXI_WSTRB : wl ? LSU_AXI_WSTRB : 8'h0,
            wi & MEM_AXI_AWREADY, wl & MEM_AXI_AWREADY, wi & MEM_AXI_WREADY, wl & MEM_AXI_WREADY,
            wi & MEM_AXI_BVALID, wl & MEM_AXI_BVALID, (wi & IFU_AXI_BREADY) | (wl & LSU_AXI_BREADY)};
  endfunction

  // Payload fields are only meaningful while some master owns the path.
  function automatic logic [90:0] act_vec();
    return {rd_grant, MEM_AXI_ARVALID, (rown != 0) ? MEM_AXI_ARADDR : 32'h0,
            IFU_AXI_ARREADY, LSU_AXI_ARREADY, IFU_AXI_RVALID, LSU_AXI_RVALID, MEM_AXI_RREADY,
            wr_grant, MEM_AXI_AWVALID, (wown != 0) ? MEM_AXI_AWADDR : 32'h0,
            MEM_AXI_WVALID, (wown != 0) ? MEM_AXI_WSTRB : 8'h0,
            IFU_AXI_AWREADY, LSU_AXI_AWREADY, IFU_AXI_WREADY, LSU_AXI_WREADY,
            IFU_AXI_BVALID, LSU_AXI_BVALID, MEM_AXI_BREADY};
  endfunction

  typedef struct {
    logic ifv, lsv, mrv, mrl, irr, lrr, marr;
    logic [7:0] exp;  // {rd_grant, MEM_ARVALID, IFU_ARREADY, LSU_ARREADY, IFU_RVALID, LSU_RVALID, MEM_RREADY}
  } vec_t;
  vec_t tbl[10];

  logic [63:0] got[4];
  logic [1:0]  gseq[4];
  int beat, cyc, n;
  bit hold_ok;

  initial begin
    tbl[0] = '{1, 1, 0, 0, 0, 0, 1, 8'b00_000000};  // tie from idle: bubble
    tbl[1] = '{1, 1, 0, 0, 0, 0, 1, 8'b10_101000};  // LSU wins, AR forwarded
    tbl[2] = '{1, 0, 1, 0, 1, 1, 0, 8'b10_000011};  // non-last beat to LSU
    tbl[3] = '{1, 0, 1, 1, 1, 0, 0, 8'b10_000010};  // RLAST but LSU not ready
    tbl[4] = '{1, 0, 1, 1, 1, 1, 0, 8'b10_000011};  // RLAST handshake releases
    tbl[5] = '{1, 0, 1, 1, 1, 1, 1, 8'b00_000000};  // idle bubble hides R traffic
    tbl[6] = '{1, 0, 0, 0, 0, 0, 1, 8'b01_110000};  // IFU served
    tbl[7] = '{0, 1, 1, 1, 1, 0, 1, 8'b01_010101};  // IFU last beat, LSU stalled
    tbl[8] = '{0, 1, 0, 0, 0, 0, 0, 8'b00_000000};  // bubble
    tbl[9] = '{0, 1, 0, 0, 0, 0, 0, 8'b10_100000};  // LSU granted, MEM not ready

    rst_n = 1'b0; clr();
    IFU_AXI_ARVALID = 1; LSU_AXI_AWVALID = 1; MEM_AXI_RVALID = 1; MEM_AXI_BVALID = 1; MEM_AXI_ARREADY = 1;
    @(negedge clk);
    chk("reset_outputs", 128'({rd_grant, wr_grant, MEM_AXI_ARVALID, MEM_AXI_AWVALID, IFU_AXI_ARREADY,
        LSU_AXI_AWREADY, IFU_AXI_RVALID, LSU_AXI_BVALID, MEM_AXI_RREADY, MEM_AXI_BREADY}), 128'(0));
    do_reset();

    foreach (tbl[i]) begin
      IFU_AXI_ARVALID = tbl[i].ifv; LSU_AXI_ARVALID = tbl[i].lsv; MEM_AXI_RVALID = tbl[i].mrv;
      MEM_AXI_RLAST = tbl[i].mrl; IFU_AXI_RREADY = tbl[i].irr; LSU_AXI_RREADY = tbl[i].lrr;
      MEM_AXI_ARREADY = tbl[i].marr;
      @(negedge clk);
      chk($sformatf("tbl_row%0d", i), 128'({rd_grant, MEM_AXI_ARVALID, IFU_AXI_ARREADY, LSU_AXI_ARREADY,
          IFU_AXI_RVALID, LSU_AXI_RVALID, MEM_AXI_RREADY}), 128'(tbl[i].exp));
      step();
    end

    // Lone IFU single-beat read.
    do_reset();
    IFU_AXI_ARVALID = 1; IFU_AXI_ARADDR = 32'h8000_0000; IFU_AXI_ARID = 4'h3; MEM_AXI_ARREADY = 1;
    @(negedge clk);
    chk("ifu_ar_bubble", 128'({rd_grant, MEM_AXI_ARVALID, IFU_AXI_ARREADY}), 128'(0));
    step(); @(negedge clk);
    chk("ifu_ar_fwd", 128'({MEM_AXI_ARVALID, MEM_AXI_ARADDR, MEM_AXI_ARID, MEM_AXI_ARLEN, IFU_AXI_ARREADY,
        LSU_AXI_ARREADY, rd_grant}), 128'({1'b1, 32'h8000_0000, 4'h3, 8'h0, 1'b1, 1'b0, 2'b01}));
    step();
    IFU_AXI_ARVALID = 0; MEM_AXI_RVALID = 1; MEM_AXI_RLAST = 1; MEM_AXI_RID = 4'h3;
    MEM_AXI_RDATA = 64'h1122_3344_5566_7788; IFU_AXI_RREADY = 1; LSU_AXI_RREADY = 1;
    @(negedge clk);
    chk("ifu_r_route", 128'({IFU_AXI_RVALID, IFU_AXI_RDATA, IFU_AXI_RID, LSU_AXI_RVALID, MEM_AXI_RREADY}),
        128'({1'b1, 64'h1122_3344_5566_7788, 4'h3, 1'b0, 1'b1}));
    step(); clr(); @(negedge clk);
    chk("ifu_r_release", 128'(rd_grant), 128'(0));

    // LSU write concurrent with IFU read.
    do_reset();
    LSU_AXI_AWVALID = 1; LSU_AXI_AWADDR = 32'h8000_1000; LSU_AXI_WVALID = 1; LSU_AXI_WLAST = 1;
    LSU_AXI_WDATA = 64'hDEAD_BEEF; LSU_AXI_WSTRB = 8'h0F; IFU_AXI_ARVALID = 1; IFU_AXI_ARADDR = 32'h8000_0040;
    MEM_AXI_AWREADY = 1; MEM_AXI_WREADY = 1; MEM_AXI_ARREADY = 1;
    step(); @(negedge clk);
    chk("rw_grants", 128'({rd_grant, wr_grant, MEM_AXI_ARVALID, MEM_AXI_ARADDR}),
        128'({2'b01, 2'b10, 1'b1, 32'h8000_0040}));
    chk("w_fwd", 128'({MEM_AXI_AWVALID, MEM_AXI_AWADDR, MEM_AXI_WVALID, MEM_AXI_WDATA, MEM_AXI_WSTRB,
        LSU_AXI_AWREADY, LSU_AXI_WREADY, IFU_AXI_AWREADY, IFU_AXI_WREADY}),
        128'({1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0}));
    step();
    LSU_AXI_AWVALID = 0; LSU_AXI_WVALID = 0; IFU_AXI_ARVALID = 0;
    MEM_AXI_BVALID = 1; MEM_AXI_BID = 4'h5; LSU_AXI_BREADY = 1; IFU_AXI_BREADY = 1;
    @(negedge clk);
    chk("b_route", 128'({LSU_AXI_BVALID, IFU_AXI_BVALID, MEM_AXI_BREADY, LSU_AXI_BID}),
        128'({1'b1, 1'b0, 1'b1, 4'h5}));
    step(); clr(); @(negedge clk);
    chk("w_release_r_held", 128'({rd_grant, wr_grant}), 128'({2'b01, 2'b00}));

    // Async reset in the middle of a burst.
    do_reset();
    LSU_AXI_ARVALID = 1; MEM_AXI_ARREADY = 1;
    step(); step();
    MEM_AXI_RVALID = 1; LSU_AXI_RREADY = 1;
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("rst_mid_burst", 128'({rd_grant, MEM_AXI_ARVALID, LSU_AXI_ARREADY, IFU_AXI_ARREADY,
        LSU_AXI_RVALID, MEM_AXI_RREADY}), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1; clr();
    @(negedge clk);
    chk("rst_idle_after", 128'({rd_grant, wr_grant}), 128'(0));

    // LSU 4-beat burst with RREADY toggling.
    do_reset();
    LSU_AXI_ARVALID = 1; LSU_AXI_ARLEN = 8'd3; MEM_AXI_ARREADY = 1;
    step(); step();
    LSU_AXI_ARVALID = 0;
    beat = 0; cyc = 0; hold_ok = 1;
    while (beat < 4 && cyc < 20) begin
      MEM_AXI_RVALID = 1; MEM_AXI_RDATA = 64'h100 + 64'(beat); MEM_AXI_RLAST = (beat == 3);
      LSU_AXI_RREADY = cyc[0];
      @(negedge clk);
      if (rd_grant != 2'b10) hold_ok = 0;
      if (LSU_AXI_RVALID && LSU_AXI_RREADY) begin got[beat] = LSU_AXI_RDATA; beat++; end
      step(); cyc++;
    end
    clr(); @(negedge clk);
    chk("burst_beats", 128'(beat), 128'(4));
    chk("burst_data", {got[0][31:0], got[1][31:0], got[2][31:0], got[3][31:0]},
        {32'h100, 32'h101, 32'h102, 32'h103});
    chk("burst_grant_held", 128'(hold_ok), 128'(1));
    chk("burst_release", 128'(rd_grant), 128'(0));

    // Back-to-back ties with responses always completing.
    do_reset();
    IFU_AXI_ARVALID = 1; LSU_AXI_ARVALID = 1; MEM_AXI_ARREADY = 1;
    MEM_AXI_RVALID = 1; MEM_AXI_RLAST = 1; IFU_AXI_RREADY = 1; LSU_AXI_RREADY = 1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 20) begin
      @(negedge clk);
      if (rd_grant != 2'b00) begin gseq[n] = rd_grant; n++; end
      step(); cyc++;
    end
    clr();
`ifdef AXI_ARB_RR_EN
    chk("tie_order", 128'({n[3:0], gseq[0], gseq[1], gseq[2], gseq[3]}), 128'({4'd4, 8'b10_01_10_01}));
`else
    chk("tie_order", 128'({n[3:0], gseq[0], gseq[1], gseq[2], gseq[3]}), 128'({4'd4, 8'b10_10_10_10}));
`endif

    // Random traffic on both paths against the ownership model.
    do_reset();
    repeat (600) begin
      rand_in();
      @(negedge clk);
      chk("random", 128'(act_vec()), 128'(exp_vec()));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
